// File: rtl/wait_fare_acc.sv
// Waiting-time fare accumulator for a taxi meter: counts stopped seconds during a trip
// and adds a BCD rate per charged waiting unit, saturating at 99.99.
module wait_fare_acc #(
    parameter int          WAIT_UNIT_S = 60,
    parameter int          FREE_UNITS  = 3,
    parameter logic [15:0] RATE_BCD    = 16'h0050
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trip_start,
    input  logic        trip_end,
    input  logic        sec_tick,
    input  logic        stopped,
    output logic [15:0] wait_fare_bcd,
    output logic [7:0]  wait_min_bcd,
    output logic        fare_update,
    output logic        sat
);

    localparam logic [7:0] LAST_SEC  = 8'(WAIT_UNIT_S - 1);
    localparam logic [7:0] FREE_UNIT = 8'(FREE_UNITS);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_sec_cnt, r_unit_cnt, r_min;
    logic [15:0] r_fare;
    logic        r_upd, r_sat;

    logic        w_count, w_wrap, w_unit_done, w_charge, w_ovf, w_fare_chg;
    logic [7:0]  w_unit_nxt, w_min_nxt;
    logic [15:0] w_sum, w_fare_nxt;
    logic [4:0]  w_dsum;
    logic        w_carry;

    // NOTE: reset is synchronous active-high, so it only appears inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (trip_start)                      w_state_nxt = RUN;
        else if (trip_end && r_state == RUN) w_state_nxt = HOLD;
    end

    // A tick only counts in RUN when no higher-priority trip event shares its cycle.
    assign w_count     = (r_state == RUN) && !trip_start && !trip_end && sec_tick && stopped;
    assign w_wrap      = (r_sec_cnt == LAST_SEC);
    assign w_unit_done = w_count && w_wrap;
    assign w_unit_nxt  = (r_unit_cnt == 8'hFF) ? 8'hFF : r_unit_cnt + 8'd1;
    assign w_charge    = w_unit_done && (w_unit_nxt > FREE_UNIT) && !r_sat;

    always_comb begin
        w_min_nxt = r_min;
        if (r_min != 8'h99) begin
            if (r_min[3:0] == 4'd9) w_min_nxt = {r_min[7:4] + 4'd1, 4'd0};
            else                    w_min_nxt = r_min + 8'd1;
        end
    end

    // Digit-wise decimal adder; the final carry is the overflow out of the thousands digit.
    always_comb begin
        w_sum   = '0;
        w_dsum  = '0;
        w_carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_dsum = {1'b0, r_fare[4*i +: 4]} + {1'b0, RATE_BCD[4*i +: 4]} + {4'd0, w_carry};
            if (w_dsum > 5'd9) begin
                w_sum[4*i +: 4] = 4'(w_dsum - 5'd10);
                w_carry         = 1'b1;
            end else begin
                w_sum[4*i +: 4] = w_dsum[3:0];
                w_carry         = 1'b0;
            end
        end
    end

    assign w_ovf      = w_carry;
    assign w_fare_nxt = w_ovf ? 16'h9999 : w_sum;
    assign w_fare_chg = (w_fare_nxt != r_fare);

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || trip_start) begin
            r_sec_cnt  <= '0;
            r_unit_cnt <= '0;
            r_min      <= '0;
            r_fare     <= '0;
            r_upd      <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_count) begin
                r_sec_cnt <= w_wrap ? 8'd0 : r_sec_cnt + 8'd1;
                if (w_wrap) begin
                    r_unit_cnt <= w_unit_nxt;
                    r_min      <= w_min_nxt;
                end
            end
            if (w_charge) begin
                r_fare <= w_fare_nxt;
                r_sat  <= w_ovf;
                r_upd  <= w_fare_chg;
            end
        end
    end

    assign wait_fare_bcd = r_fare;
    assign wait_min_bcd  = r_min;
    assign fare_update   = r_upd;
    assign sat           = r_sat;

endmodule
